// File: rtl/audio_in_reader.sv
// ADC-side reader for the audio CODEC: pops sample pairs, downmixes to mono,
// tracks a windowed peak level and a hysteresis "loud" flag.
`timescale 1ns/1ps
module audio_in_reader #(
    parameter int         WINDOW_LOG2 = 11,
    parameter logic [7:0] THRESH_ON   = 8'd96,
    parameter logic [7:0] THRESH_OFF  = 8'd64
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        enable,
    input  logic        read_ready,
    input  logic [23:0] readdata_left,
    input  logic [23:0] readdata_right,
    output logic        read,
    output logic        sample_valid,
    output logic [23:0] sample_mono,
    output logic [7:0]  level,
    output logic        loud
);

    // A zero-length window still needs a one-bit counter; it simply never leaves 0.
    localparam int               CNT_W    = (WINDOW_LOG2 > 0) ? WINDOW_LOG2 : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((64'd1 << WINDOW_LOG2) - 64'd1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_WAIT    = 2'd2
    } state_t;

    state_t           state_r;
    logic [CNT_W-1:0] win_cnt_r;
    logic [7:0]       run_max_r;
    logic [7:0]       level_smp_s;
    logic [7:0]       peak_s;

    // (L+R)/2 with a 25-bit sum so the add cannot overflow; shift floors toward -inf.
    function automatic logic [23:0] mono_mix(input logic [23:0] l, input logic [23:0] r);
        logic [24:0] sum;
        sum = {l[23], l} + {r[23], r};
        return 24'(sum >> 1);
    endfunction

    // Top 8 bits of the 23-bit magnitude; the most negative code saturates.
    function automatic logic [7:0] level_of(input logic [23:0] m);
        logic [23:0] abs_v;
        if (m == 24'h800000) begin
            abs_v = 24'h7FFFFF;
        end else if (m[23]) begin
            abs_v = ~m + 24'd1;
        end else begin
            abs_v = m;
        end
        return 8'(abs_v >> 15);
    endfunction

    // Level of the sample held in CAPTURE and the running peak including it.
    always_comb begin
        level_smp_s = level_of(sample_mono);
        if (level_smp_s > run_max_r) begin
            peak_s = level_smp_s;
        end else begin
            peak_s = run_max_r;
        end
    end

    // Handshake FSM with registered outputs, peak window and hysteresis update.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r      <= ST_IDLE;
            read         <= 1'b0;
            sample_valid <= 1'b0;
            sample_mono  <= 24'd0;
            level        <= 8'd0;
            loud         <= 1'b0;
            win_cnt_r    <= '0;
            run_max_r    <= 8'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (enable && read_ready) begin
                        state_r      <= ST_CAPTURE;
                        read         <= 1'b1;
                        sample_valid <= 1'b1;
                        sample_mono  <= mono_mix(readdata_left, readdata_right);
                    end else begin
                        state_r      <= ST_IDLE;
                        read         <= 1'b0;
                        sample_valid <= 1'b0;
                    end
                end
                ST_CAPTURE: begin
                    state_r      <= ST_WAIT;
                    read         <= 1'b0;
                    sample_valid <= 1'b0;
                    if (win_cnt_r == CNT_LAST) begin
                        level     <= peak_s;
                        run_max_r <= 8'd0;
                        win_cnt_r <= '0;
                        if (peak_s >= THRESH_ON) begin
                            loud <= 1'b1;
                        end else if (peak_s < THRESH_OFF) begin
                            loud <= 1'b0;
                        end else begin
                            loud <= loud;
                        end
                    end else begin
                        run_max_r <= peak_s;
                        win_cnt_r <= win_cnt_r + CNT_W'(1);
                    end
                end
                ST_WAIT: begin
                    // One dead cycle lets the CODEC retire read_ready.
                    state_r      <= ST_IDLE;
                    read         <= 1'b0;
                    sample_valid <= 1'b0;
                end
                default: begin
                    state_r      <= ST_IDLE;
                    read         <= 1'b0;
                    sample_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/audio_in_reader.md
Name: audio_in_reader

Overview:
- Reader side of the audio CODEC sample interface; drains ADC samples via the `read_ready`/`read` handshake, the mirror of the existing DAC `write` path.
- Downmixes left/right to mono and tracks a windowed peak level.
- Drives a hysteresis `loud` flag so microphone volume can serve as an alternate plane-control input.
- Sits between `audio_codec` and the game logic, clocked by `CLOCK_50`.

Parameters:
- WINDOW_LOG2, 11, peak window = 2^WINDOW_LOG2 samples (2048 ≈ 42.7 ms at 48 kHz).
- THRESH_ON, 96, `level` >= this sets `loud`.
- THRESH_OFF, 64, `level` < this clears `loud`; THRESH_OFF <= THRESH_ON required.

Ports:
- clk  input  1  system clock (`CLOCK_50`).
- resetn  input  1  asynchronous active-low reset.
- enable  input  1  when low, no new reads start.
- read_ready  input  1  CODEC has an ADC sample pair available.
- readdata_left  input  24  left sample, two's complement, valid while `read_ready`=1.
- readdata_right  input  24  right sample, two's complement.
- read  output  1  one-cycle pop strobe to CODEC.
- sample_valid  output  1  one-cycle pulse, `sample_mono` updated.
- sample_mono  output  24  (L+R)/2, two's complement.
- level  output  8  peak magnitude over last completed window.
- loud  output  1  hysteresis flag derived from `level`.

Behaviour:
- Reset: every register clears while `resetn`=0, independent of `clk`.
  - state=IDLE, read=0, sample_valid=0, sample_mono=0, level=0, loud=0.
  - Window counter=0, running max=0.
- FSM is Moore; all outputs are registered.
  - IDLE: if enable=1 and read_ready=1 at a rising edge, capture both samples and go to CAPTURE. Otherwise stay.
  - CAPTURE (1 cycle): read=1, sample_valid=1, sample_mono holds the new value. Go to WAIT.
  - WAIT (1 cycle): read=0. Go to IDLE unconditionally. This gives the CODEC one cycle to update `read_ready`.
  - Max throughput: one sample per 3 clocks. `read` is never high on two consecutive cycles.
- Latency: `read_ready` sampled high at edge k gives read=1 and sample_valid=1 for the cycle between edges k and k+1.
- `enable` is checked only in IDLE. Deasserting it in CAPTURE/WAIT finishes the current transaction.
- Mono arithmetic:
  - Sign-extend L and R to 25 bits and add.
  - Arithmetic shift right 1, keep low 24 bits. Rounds toward −inf, never overflows.
- Magnitude: mag = |sample_mono| as 23 bits. −2^23 saturates to 2^23−1.
  - Level sample = mag[22:15].
- Peak window: evaluated on the edge leaving CAPTURE.
  - m = max(running_max, current level sample).
  - If window counter = 2^WINDOW_LOG2−1: level <= m, running_max <= 0, counter <= 0.
  - Else: running_max <= m, counter += 1.
  - Counter is WINDOW_LOG2 bits. `level` changes only at window end, first visible in the WAIT cycle.
- loud: updated in the same edge as `level`, using the new level value.
  - Set if new level >= THRESH_ON.
  - Clear if new level < THRESH_OFF.
  - Otherwise hold.
- Reset mid-transaction (CAPTURE or WAIT): `read` drops immediately, no partial sample is reported, window restarts.
- `read_ready` toggling while in CAPTURE or WAIT is ignored.

Test Plan:
- Reset + idle: assert resetn=0 with read_ready=1 → read=0, all outputs 0. Release with enable=0 → read stays 0 for 100 cycles.
- Single handshake: enable=1, L=24'h000100, R=24'h000300, read_ready pulsed 1 → read=1 for exactly one cycle one edge later, sample_valid coincident, sample_mono=24'h000200. Next read no earlier than 3 cycles later.
- Arithmetic edges:
  - L=R=24'h800000 → sample_mono=24'h800000, level sample 8'hFF (saturated).
  - L=24'h7FFFFF, R=24'h800000 → sample_mono=24'hFFFFFF, level sample 0.
  - L=R=24'h7FFFFF → 24'h7FFFFF.
- Peak window (WINDOW_LOG2=2): level samples 10, 200, 30, 40 → level=200 after 4th transaction. Next window 5, 6, 7, 8 → level=8.
- Hysteresis (WINDOW_LOG2=0): level sequence 50, 100, 80, 70, 63, 96 → loud = 0, 1, 1, 1, 0, 1.
- Reset mid-CAPTURE: drop resetn during read=1 → read=0 asynchronously, level=0, counter restarts. The next full window reports only post-reset samples.
